// File: rtl/rf_write_if.sv
// Write-request bundle between the two writeback sources, the
// issue stage and the register-file write arbiter.
interface rf_write_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              resv_valid;
    logic [ADDR_W-1:0] resv_reg;

    modport master (
        output a_valid, a_reg, a_data,
        input  a_ready,
        output b_valid, b_reg, b_data,
        input  b_ready,
        output resv_valid, resv_reg
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        output a_ready,
        input  b_valid, b_reg, b_data,
        output b_ready,
        input  resv_valid, resv_reg
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-source register-file write arbiter with one-entry buffers,
// round-robin grant, x0 suppression and a pending-write scoreboard.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    rf_write_if.slave         bus,
    output logic              wEn,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [31:0]       pending,
    output logic [7:0]        conflicts,
    output logic              last_grant
);
    logic              full_a;
    logic              full_b;
    logic [ADDR_W-1:0] reg_a;
    logic [ADDR_W-1:0] reg_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              grant_a;
    logic              grant_b;
    logic              grant_any;
    logic              contend;
    logic              load_a;
    logic              load_b;
    logic [ADDR_W-1:0] gnt_reg;
    logic [DATA_W-1:0] gnt_data;
    logic [31:0]       pend_nxt;

    // Grants come only from registered state, so ready never
    // depends combinationally on valid.
    assign contend   = full_a && full_b;
    assign grant_a   = full_a && (!full_b || last_grant);
    assign grant_b   = full_b && (!full_a || !last_grant);
    assign grant_any = grant_a || grant_b;
    assign gnt_reg   = grant_b ? reg_b : reg_a;
    assign gnt_data  = grant_b ? data_b : data_a;

    assign bus.a_ready = !full_a || grant_a;
    assign bus.b_ready = !full_b || grant_b;

    // Writes to x0 are accepted but never buffered.
    assign load_a = bus.a_valid && bus.a_ready && (bus.a_reg != '0);
    assign load_b = bus.b_valid && bus.b_ready && (bus.b_reg != '0);

    // Holding buffers: a same-cycle reload wins over the grant clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_a <= 1'b0;
            reg_a  <= '0;
            data_a <= '0;
            full_b <= 1'b0;
            reg_b  <= '0;
            data_b <= '0;
        end else begin
            if (load_a) begin
                full_a <= 1'b1;
                reg_a  <= bus.a_reg;
                data_a <= bus.a_data;
            end else if (grant_a) begin
                full_a <= 1'b0;
            end
            if (load_b) begin
                full_b <= 1'b1;
                reg_b  <= bus.b_reg;
                data_b <= bus.b_data;
            end else if (grant_b) begin
                full_b <= 1'b0;
            end
        end
    end

    // Register-file write port, round-robin pointer and contention counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wEn        <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            last_grant <= 1'b1;
            conflicts  <= 8'd0;
        end else begin
            wEn <= grant_any;
            if (grant_any) begin
                write_reg  <= gnt_reg;
                write_data <= gnt_data;
                last_grant <= grant_b;
            end
            if (contend && (conflicts != 8'hFF)) begin
                conflicts <= conflicts + 8'd1;
            end
        end
    end

    // Scoreboard next state: clear on grant, then set on reserve so set wins.
    always_comb begin
        pend_nxt = pending;
        if (grant_any) begin
            pend_nxt[gnt_reg] = 1'b0;
        end
        if (bus.resv_valid) begin
            pend_nxt[bus.resv_reg] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 32'd0;
        end else begin
            pending <= pend_nxt;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued
// at handshake time and matched against the write port.
module tb_rf_write_arbiter;
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        clock;
    logic        reset;
    logic        wEn;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [7:0]  conflicts;
    logic        last_grant;

    rf_write_if #(.DATA_W(32), .ADDR_W(5)) ifc ();

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (ifc),
        .wEn        (wEn),
        .write_reg  (write_reg),
        .write_data (write_data),
        .pending    (pending),
        .conflicts  (conflicts),
        .last_grant (last_grant)
    );

    wr_t         sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_push = 0;
    int          wen_cnt = 0;
    int          wen_runs = 0;
    logic        prev_wen = 1'b0;
    logic        hs_a;
    logic        hs_b;
    logic [31:0] rf [32];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file fed by the write port.
    always @(posedge clock) begin
        if (wEn) rf[write_reg] <= write_data;
    end

    // Write-port monitor: pop the oldest expected write on every wEn.
    always @(negedge clock) begin
        wr_t e;
        if (reset === 1'b1 && wEn === 1'b1) begin
            wen_cnt++;
            if (!prev_wen) wen_runs++;
            if (sb.size() == 0) begin
                check("spurious_wen", {63'd0, wEn}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("wr_reg", {59'd0, write_reg}, {59'd0, e.r});
                check("wr_data", {32'd0, write_data}, {32'd0, e.d});
            end
        end
        prev_wen = (reset === 1'b1) && (wEn === 1'b1);
    end

    task automatic step();
        wr_t e;
        @(negedge clock);
        hs_a = ifc.a_valid && ifc.a_ready;
        hs_b = ifc.b_valid && ifc.b_ready;
        if (hs_a && ifc.a_reg != 5'd0) begin
            e.r = ifc.a_reg;
            e.d = ifc.a_data;
            sb.push_back(e);
            n_push++;
        end
        if (hs_b && ifc.b_reg != 5'd0) begin
            e.r = ifc.b_reg;
            e.d = ifc.b_data;
            sb.push_back(e);
            n_push++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        ifc.a_valid    = 1'b0;
        ifc.b_valid    = 1'b0;
        ifc.resv_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        quiet();
        reset = 1'b0;
        sb.delete();
        idle(2);
        reset = 1'b1;
    endtask

    task automatic stream(input int n);
        int ai;
        int bi;
        ai = 0;
        bi = 0;
        for (int c = 0; c < n; c++) begin
            ifc.a_valid = 1'b1;
            ifc.a_reg   = 5'(1 + ai % 31);
            ifc.a_data  = 32'hA000_0000 + 32'(ai);
            ifc.b_valid = 1'b1;
            ifc.b_reg   = 5'(1 + (bi + 15) % 31);
            ifc.b_data  = 32'hB000_0000 + 32'(bi);
            step();
            if (hs_a) ai++;
            if (hs_b) bi++;
        end
        ifc.a_valid = 1'b0;
        ifc.b_valid = 1'b0;
    endtask

    initial begin
        int w0;
        int r0;
        int p0;
        reset = 1'b1;
        quiet();
        ifc.a_reg = '0;
        ifc.a_data = '0;
        ifc.b_reg = '0;
        ifc.b_data = '0;
        ifc.resv_reg = '0;
        #3 reset = 1'b0;
        #1;
        check("rst_wen", {63'd0, wEn}, 64'd0);
        check("rst_wreg", {59'd0, write_reg}, 64'd0);
        check("rst_wdata", {32'd0, write_data}, 64'd0);
        check("rst_pending", {32'd0, pending}, 64'd0);
        check("rst_conflicts", {56'd0, conflicts}, 64'd0);
        check("rst_last_grant", {63'd0, last_grant}, 64'd1);
        check("rst_a_ready", {63'd0, ifc.a_ready}, 64'd1);
        check("rst_b_ready", {63'd0, ifc.b_ready}, 64'd1);
        idle(2);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_a_ready", {63'd0, ifc.a_ready}, 64'd1);
        check("post_rst_b_ready", {63'd0, ifc.b_ready}, 64'd1);
        @(posedge clock);
        #1;

        // Single uncontended write: wEn exactly one cycle after acceptance.
        ifc.a_valid = 1'b1;
        ifc.a_reg   = 5'd5;
        ifc.a_data  = 32'h0000_000D;
        check("single_a_ready", {63'd0, ifc.a_ready}, 64'd1);
        step();
        ifc.a_valid = 1'b0;
        check("single_wen_early", {63'd0, wEn}, 64'd0);
        idle(1);
        check("single_wen", {63'd0, wEn}, 64'd1);
        check("single_wreg", {59'd0, write_reg}, 64'd5);
        check("single_wdata", {32'd0, write_data}, 64'h0D);
        idle(1);
        check("single_wen_off", {63'd0, wEn}, 64'd0);
        check("single_hold_wdata", {32'd0, write_data}, 64'h0D);
        check("single_rf5", {32'd0, rf[5]}, 64'h0D);

        // Contention right after reset: A first, then B.
        do_reset();
        ifc.a_valid = 1'b1;
        ifc.a_reg   = 5'd6;
        ifc.a_data  = 32'h7;
        ifc.b_valid = 1'b1;
        ifc.b_reg   = 5'd7;
        ifc.b_data  = 32'h9;
        step();
        quiet();
        idle(4);
        check("cont_conflicts", {56'd0, conflicts}, 64'd1);
        check("cont_last_grant", {63'd0, last_grant}, 64'd1);
        check("cont_rf6", {32'd0, rf[6]}, 64'h7);
        check("cont_rf7", {32'd0, rf[7]}, 64'h9);
        check("cont_drained", 64'(sb.size()), 64'd0);

        // Sustained round robin for 8 cycles: one unbroken burst.
        do_reset();
        w0 = wen_cnt;
        r0 = wen_runs;
        p0 = n_push;
        stream(8);
        idle(6);
        check("rr_writes", 64'(wen_cnt - w0), 64'(n_push - p0));
        check("rr_no_bubble", 64'(wen_runs - r0), 64'd1);
        check("rr_conflicts", {56'd0, conflicts}, 64'd8);
        check("rr_drained", 64'(sb.size()), 64'd0);

        // Long contention run saturates the counter.
        do_reset();
        stream(300);
        idle(6);
        check("sat_conflicts", {56'd0, conflicts}, 64'd255);
        check("sat_drained", 64'(sb.size()), 64'd0);

        // Scoreboard set, clear on grant, x0 reserve ignored.
        do_reset();
        ifc.resv_valid = 1'b1;
        ifc.resv_reg   = 5'd9;
        step();
        ifc.resv_reg   = 5'd0;
        step();
        ifc.resv_valid = 1'b0;
        check("sb_set", {32'd0, pending}, 64'h200);
        ifc.a_valid = 1'b1;
        ifc.a_reg   = 5'd9;
        ifc.a_data  = 32'h99;
        step();
        ifc.a_valid = 1'b0;
        check("sb_before_grant", {32'd0, pending}, 64'h200);
        idle(1);
        check("sb_cleared", {32'd0, pending}, 64'h0);
        ifc.resv_valid = 1'b1;
        ifc.resv_reg   = 5'd9;
        step();
        ifc.resv_valid = 1'b0;
        ifc.a_valid = 1'b1;
        ifc.a_data  = 32'h9A;
        step();
        ifc.a_valid    = 1'b0;
        ifc.resv_valid = 1'b1;
        step();
        ifc.resv_valid = 1'b0;
        check("sb_set_wins", {32'd0, pending}, 64'h200);
        idle(3);
        check("sb_rf9", {32'd0, rf[9]}, 64'h9A);

        // Write to x0 is accepted and dropped.
        w0 = wen_cnt;
        ifc.b_valid = 1'b1;
        ifc.b_reg   = 5'd0;
        ifc.b_data  = 32'hFFFF_FFFF;
        check("x0_b_ready", {63'd0, ifc.b_ready}, 64'd1);
        step();
        ifc.b_valid = 1'b0;
        idle(4);
        check("x0_no_wen", 64'(wen_cnt - w0), 64'd0);
        check("x0_pending", {32'd0, pending}, 64'h200);

        // Reset pulsed while both buffers hold writes.
        do_reset();
        ifc.resv_valid = 1'b1;
        ifc.resv_reg   = 5'd3;
        ifc.a_valid = 1'b1;
        ifc.a_reg   = 5'd11;
        ifc.a_data  = 32'h11;
        ifc.b_valid = 1'b1;
        ifc.b_reg   = 5'd12;
        ifc.b_data  = 32'h12;
        step();
        ifc.resv_valid = 1'b0;
        ifc.a_data  = 32'h111;
        step();
        quiet();
        check("mid_wen_before", {63'd0, wEn}, 64'd1);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check("mid_wen", {63'd0, wEn}, 64'd0);
        check("mid_pending", {32'd0, pending}, 64'd0);
        check("mid_conflicts", {56'd0, conflicts}, 64'd0);
        check("mid_a_ready", {63'd0, ifc.a_ready}, 64'd1);
        idle(2);
        reset = 1'b1;
        w0 = wen_cnt;
        idle(6);
        check("mid_no_stale", 64'(wen_cnt - w0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
